dcache_responder: RTL and testbench

Data-side memory responder at the far end of the Mem-stage Dcache request interface. It accepts the enable/read/width/address/sign request and returns aligned, sign- or zero-extended load data with a one-cycle stall. Stores commit with byte-lane enables into a local word-organised SRAM array. It is the data memory seen by the Mem stage of the core pipeline.

---
 rtl/dcache_responder_pkg.sv | 28 ++
 rtl/dcache_lane_align.sv | 74 +++++++
 rtl/dcache_responder.sv | 145 ++++++++++++++
 tb/tb_dcache_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the Dcache responder.
//   - Width encodings of Mem_DcacheWidth (11 behaves as word)
//   - FSM state encoding
//   - default array depth (log2 words)
//   - misalignment predicate shared by the RTL
package dcache_responder_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam int DEPTH_LOG2_DEF = 10;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_LOAD_RESP = 1'b1
  } state_t;

  // Half needs an even offset, word/11 needs offset 0, byte is always aligned.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      W_BYTE:  return 1'b0;
      W_HALF:  return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Combinational lane steering for the Dcache responder.
//   Store side: byte enables and replicated write data from width/offset.
//   Load side : lane extraction from a full word plus sign/zero extension.
//   Misalign  : reported only when DCACHE_MISALIGN_TRAP_EN is defined;
//               otherwise low offset bits are forced to alignment.
// Ports:
//   i_width, i_off, i_sign   access descriptor (width, byte offset, sign)
//   i_wr_data                right-justified store data
//   i_rd_word                full word read from the array
//   o_be, o_wr_data          per-byte write enables and lane-replicated data
//   o_rd_data                extended load result
//   o_misalign               misaligned access flag
module dcache_lane_align
  import dcache_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              i_width,
  input  logic [1:0]              i_off,
  input  logic                    i_sign,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH-1:0]   i_rd_word,
  output logic [DATA_WIDTH/8-1:0] o_be,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_misalign
);

  localparam int NB = DATA_WIDTH / 8;

  logic              w_byte;
  logic              w_half;
  logic              w_mis_raw;
  logic [1:0]        w_off;
  logic [NB-1:0]     w_be_base;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_byte    = (i_width == W_BYTE);
  assign w_half    = (i_width == W_HALF);
  assign w_mis_raw = is_misaligned(i_width, i_off);

`ifdef DCACHE_MISALIGN_TRAP_EN
  assign w_off      = i_off;
  assign o_misalign = w_mis_raw;
`else
  // No trap: drop the offset bits that would break alignment.
  logic w_unused_mis;
  assign w_unused_mis = w_mis_raw;
  assign w_off      = w_byte ? i_off : (w_half ? {i_off[1], 1'b0} : 2'b00);
  assign o_misalign = 1'b0;
`endif

  assign w_be_base = w_byte ? NB'(1) : (w_half ? NB'(3) : {NB{1'b1}});
  // A trapped store must leave the array untouched.
  assign o_be      = (w_be_base << w_off) & ~{NB{o_misalign}};

  assign o_wr_data = w_byte ? {NB{i_wr_data[7:0]}} :
                     w_half ? {(NB/2){i_wr_data[15:0]}} : i_wr_data;

  assign w_shifted = i_rd_word >> {w_off, 3'b000};

  always_comb begin
    o_rd_data = '0;
    if (w_byte)
      o_rd_data = {{(DATA_WIDTH-8){i_sign & w_shifted[7]}}, w_shifted[7:0]};
    else if (w_half)
      o_rd_data = {{(DATA_WIDTH-16){i_sign & w_shifted[15]}}, w_shifted[15:0]};
    else
      o_rd_data = w_shifted;
    if (o_misalign)
      o_rd_data = '0;
  end

endmodule

// File: rtl/dcache_responder.sv
// Data memory behind the Mem-stage Dcache request interface.
// Stores complete combinationally in the accept cycle and commit at the
// edge; loads stall one cycle, read into a registered word, and respond
// from LOAD_RESP with lane extraction done on the latched offset/width/sign.
// Optional feature macro: DCACHE_MISALIGN_TRAP_EN (misalign trap).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   Mem_Dcache*        request: EN, Rd, Width, Addr, Sign, WrData
//   Dcache_RdData      extended load data (with Dcache_Valid)
//   Dcache_Valid       access complete this cycle
//   Dcache_Stall       hold the Mem stage
//   Dcache_Misalign    misaligned access (with Dcache_Valid)
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic                  Mem_DcacheSign,
  input  logic [DATA_WIDTH-1:0] Mem_DcacheWrData,
  output logic [DATA_WIDTH-1:0] Dcache_RdData,
  output logic                  Dcache_Valid,
  output logic                  Dcache_Stall,
  output logic                  Dcache_Misalign
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdword;
  logic [1:0]            r_off;
  logic [1:0]            r_width;
  logic                  r_sign;

  logic                  w_resp;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_al_width;
  logic [1:0]            w_al_off;
  logic                  w_al_sign;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_mis;
  logic                  w_wr_en;
  logic                  w_ld_acc;

  // Upper address bits alias onto the array.
  logic w_unused_addr;
  assign w_unused_addr = ^Mem_DcacheAddr[ADDR_WIDTH-1:DEPTH_LOG2+2];

  assign w_resp = (r_state == S_LOAD_RESP);
  assign w_idx  = Mem_DcacheAddr[DEPTH_LOG2+1:2];

  // In LOAD_RESP the aligner works on the latched descriptor so that
  // request changes during the stall cycle are ignored.
  assign w_al_width = w_resp ? r_width : Mem_DcacheWidth;
  assign w_al_off   = w_resp ? r_off   : Mem_DcacheAddr[1:0];
  assign w_al_sign  = w_resp ? r_sign  : Mem_DcacheSign;

  dcache_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_width    (w_al_width),
    .i_off      (w_al_off),
    .i_sign     (w_al_sign),
    .i_wr_data  (Mem_DcacheWrData),
    .i_rd_word  (r_rdword),
    .o_be       (w_be),
    .o_wr_data  (w_wr_data),
    .o_rd_data  (w_rd_data),
    .o_misalign (w_mis)
  );

  assign w_wr_en  = rst_n && !w_resp && Mem_DcacheEN && !Mem_DcacheRd;
  assign w_ld_acc = !w_resp && Mem_DcacheEN && Mem_DcacheRd;

  // Array is not reset; byte-lane write enables.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < NB; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rdword <= '0;
      r_off    <= '0;
      r_width  <= '0;
      r_sign   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ld_acc) begin
        r_rdword <= r_mem[w_idx];
        r_off    <= Mem_DcacheAddr[1:0];
        r_width  <= Mem_DcacheWidth;
        r_sign   <= Mem_DcacheSign;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    Dcache_Valid    = 1'b0;
    Dcache_Stall    = 1'b0;
    Dcache_RdData   = '0;
    Dcache_Misalign = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Mem_DcacheEN) begin
          if (Mem_DcacheRd) begin
            Dcache_Stall = 1'b1;
            w_next       = S_LOAD_RESP;
          end else begin
            Dcache_Valid    = 1'b1;
            Dcache_Misalign = w_mis;
          end
        end
      end
      S_LOAD_RESP: begin
        Dcache_Valid    = 1'b1;
        Dcache_RdData   = w_rd_data;
        Dcache_Misalign = w_mis;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Outputs are quiet for the whole reset window, not just after an edge.
    if (!rst_n) begin
      Dcache_Valid    = 1'b0;
      Dcache_Stall    = 1'b0;
      Dcache_RdData   = '0;
      Dcache_Misalign = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: stimulus pushes expected
// responses into a queue, a negedge monitor pops and compares whenever
// Dcache_Valid is seen. Reference memory is a byte array.
module tb_dcache_responder;

  logic        clk;
  logic        rst_n;
  logic        en, rd, sign;
  logic [1:0]  width;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        valid, stall, mis;

  dcache_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Mem_DcacheEN    (en),
    .Mem_DcacheRd    (rd),
    .Mem_DcacheWidth (width),
    .Mem_DcacheAddr  (addr),
    .Mem_DcacheSign  (sign),
    .Mem_DcacheWrData(wdata),
    .Dcache_RdData   (rdata),
    .Dcache_Valid    (valid),
    .Dcache_Stall    (stall),
    .Dcache_Misalign (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mref [0:4095];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference: byte-addressed 4 KiB memory, 32-bit words little-endian.
  function automatic logic ref_mis(input logic [1:0] w, input logic [31:0] a);
`ifdef DCACHE_MISALIGN_TRAP_EN
    if (w == 2'd1) return a[0];
    if (w >= 2'd2) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic int ref_base(input logic [1:0] w, input logic [31:0] a);
    int b;
    b = a % 4096;
    return b - (b % nbytes(w));
  endfunction

  task automatic ref_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    int b;
    if (ref_mis(w, a)) return;
    b = ref_base(w, a);
    for (int i = 0; i < nbytes(w); i++) mref[b + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] w, input logic [31:0] a,
                                          input logic s);
    int          b, n;
    logic [31:0] v;
    if (ref_mis(w, a)) return 32'h0;
    b = ref_base(w, a);
    n = nbytes(w);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mref[b + i]) << (8*i));
    if (s && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (s && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic drive(input logic e, input logic r, input logic [1:0] w,
                       input logic [31:0] a, input logic s, input logic [31:0] d);
    en = e; rd = r; width = w; addr = a; sign = s; wdata = d;
  endtask

  task automatic do_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, w, a, $urandom_range(0, 1), d);
    e.ld = 1'b0; e.data = 32'h0; e.mis = ref_mis(w, a);
    q.push_back(e);
    ref_store(w, a, d);
  endtask

  // use_k: compare against a hand-derived constant instead of the model.
  task automatic do_load(input logic [1:0] w, input logic [31:0] a, input logic s,
                         input logic use_k, input logic [31:0] k, input logic kmis);
    exp_t e;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, w, a, s, $urandom);
    e.ld   = 1'b1;
    e.data = use_k ? k : ref_load(w, a, s);
    e.mis  = use_k ? kmis : ref_mis(w, a);
    q.push_back(e);
    @(negedge clk);
    chk("load_accept_stall_valid", {62'd0, stall, valid}, 64'd2);
    @(posedge clk); #1;
    // Perturb the held request: the response must use the latched fields.
    width = 2'($urandom_range(0, 3));
    addr  = $urandom;
    sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    drive(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b0, $urandom);
  endtask

  // Monitor: one pop per completed access.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.ld) chk("load_data", {32'd0, rdata}, {32'd0, e.data});
        chk("misalign", {63'd0, mis}, {63'd0, e.mis});
        chk("stall_with_valid", {63'd0, stall}, 64'd0);
      end
    end
  end

  function automatic logic [31:0] rnd_addr();
    return ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);

    // Reset window: requests are ignored, outputs stay 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b1, $urandom);
      @(negedge clk);
      chk("reset_valid_stall", {62'd0, valid, stall}, 64'd0);
      chk("reset_rddata", {32'd0, rdata}, 64'd0);
    end
    #1 rst_n = 1'b1;
    en = 1'b0;

    // Fill the test region so every later load has defined contents.
    for (int i = 0; i < 256; i += 4) do_store(2'd2, 32'(i), $urandom);

    do_store(2'd2, 32'h40, 32'h8000_00F0);
    do_load (2'd2, 32'h40, 1'b0, 1'b1, 32'h8000_00F0, 1'b0);

    do_store(2'd2, 32'h10, 32'h1122_8344);
    do_load (2'd0, 32'h11, 1'b1, 1'b1, 32'hFFFF_FF83, 1'b0);
    do_load (2'd0, 32'h11, 1'b0, 1'b1, 32'h0000_0083, 1'b0);
    do_load (2'd1, 32'h12, 1'b0, 1'b1, 32'h0000_1122, 1'b0);

    do_store(2'd0, 32'h13, 32'h0000_00AB);
    do_load (2'd2, 32'h10, 1'b0, 1'b1, 32'hAB22_8344, 1'b0);
    do_load (2'd1, 32'h12, 1'b1, 1'b1, 32'hFFFF_AB22, 1'b0);
    do_load (2'd3, 32'h10, 1'b1, 1'b1, 32'hAB22_8344, 1'b0);
    do_load (2'd0, 32'h8000_1010, 1'b0, 1'b1, 32'h0000_0044, 1'b0);

`ifdef DCACHE_MISALIGN_TRAP_EN
    do_load (2'd2, 32'h42, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
`else
    do_load (2'd2, 32'h42, 1'b0, 1'b1, 32'h8000_00F0, 1'b0);
`endif
    do_store(2'd2, 32'h41, 32'hDEAD_BEEF);
    do_load (2'd2, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    do_idle();

    // Reset during LOAD_RESP: no response, outputs drop at once.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 2'd2, 32'h10, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("loadresp_before_reset", {62'd0, valid, stall}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_midload_valid_stall", {62'd0, valid, stall}, 64'd0);
    en = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    do_load (2'd2, 32'h10, 1'b0, 1'b1, 32'hAB22_8344, 1'b0);

    // Randomized mix against the reference memory.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 4)      do_store(2'($urandom_range(0, 3)), rnd_addr(), $urandom);
      else if (op < 9) do_load (2'($urandom_range(0, 3)), rnd_addr(), 1'($urandom_range(0, 1)),
                                1'b0, 32'h0, 1'b0);
      else             do_idle();
    end
    do_idle();

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
